// File: rtl/poly_add_sched.sv
// Polynomial add/sub sequencer: streams a[k], b[k] through mod_add
// into the result RAM at one coefficient per cycle.

module mod_add (
  input  logic [23:0] a_i,
  input  logic [23:0] b_i,
  input  logic [22:0] q_i,
  output logic [22:0] r_o
);
  logic [24:0] sum;
  logic [24:0] red;

  assign sum = {1'b0, a_i} + {1'b0, b_i};
  assign red = (sum >= {2'b00, q_i}) ? sum - {2'b00, q_i} : sum;
  assign r_o = red[22:0];
endmodule

module poly_add_sched #(
  parameter int N  = 256,
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          op_i,
  input  logic [22:0]   q_i,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [22:0]   a_i,
  input  logic [22:0]   b_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [22:0]   wr_data_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          range_err_o
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_q;
  logic          rd_en_q;
  logic [AW-1:0] rd_addr_q;
  logic          busy_q;
  logic          done_q;
  logic [22:0]   q_q;
  logic          op_q;
  logic          s1_v_q;
  logic [AW-1:0] s1_addr_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [22:0]   wr_data_q;
  logic          err_q;

  logic          accept;
  logic          kill;
  logic          bad;
  logic [23:0]   b_d;
  logic [22:0]   sum_d;

  assign accept = (state_q == IDLE) & start_i & ~abort_i;
  assign kill   = abort_i & (state_q != IDLE);

  // q - b keeps the operand non-negative; a + q < 2^24 always fits
  assign b_d = op_q ? ({1'b0, q_q} - {1'b0, b_i}) : {1'b0, b_i};
  assign bad = s1_v_q & ((a_i >= q_q) | (b_i >= q_q));

  mod_add u_mod_add (
    .a_i ({1'b0, a_i}),
    .b_i (b_d),
    .q_i (q_q),
    .r_o (sum_d)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      q_q       <= '0;
      op_q      <= 1'b0;
    end else if (kill) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= RUN;
            q_q       <= q_i;
            op_q      <= op_i;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          if (rd_addr_q == AW'(N - 1)) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          // stage 1 empty means the final write is on the outputs now
          if (!s1_v_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_v_q    <= 1'b0;
      s1_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept)
        err_q <= 1'b0;
      else if (bad)
        err_q <= 1'b1;
      if (kill) begin
        s1_v_q  <= 1'b0;
        wr_en_q <= 1'b0;
      end else begin
        s1_v_q    <= rd_en_q;
        s1_addr_q <= rd_addr_q;
        wr_en_q   <= s1_v_q;
        wr_addr_q <= s1_addr_q;
        wr_data_q <= sum_d;
      end
    end
  end

  assign rd_en_o     = rd_en_q;
  assign rd_addr_o   = rd_addr_q;
  assign wr_en_o     = wr_en_q & ~kill;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign range_err_o = err_q | bad;
endmodule

// File: tb/tb_poly_add_sched.sv
// Bench for poly_add_sched: RAM models, write scoreboard, timing checks.

module tb_poly_add_sched;
  localparam int N  = 256;
  localparam int AW = 8;
  localparam logic [22:0] Q = 23'h7FE001;

  typedef struct {
    logic [AW-1:0] addr;
    logic [22:0]   data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          op_i = 1'b0;
  logic [22:0]   q_i = '0;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [22:0]   a_i = '0;
  logic [22:0]   b_i = '0;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [22:0]   wr_data_o;
  logic          busy_o;
  logic          done_o;
  logic          range_err_o;

  logic [22:0] mem_a [N];
  logic [22:0] mem_b [N];
  logic [22:0] mem_c [N];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;

  poly_add_sched #(.N(N), .AW(AW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .op_i        (op_i),
    .q_i         (q_i),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .range_err_o (range_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en_o) begin
      a_i <= mem_a[rd_addr_o];
      b_i <= mem_b[rd_addr_o];
    end
    if (wr_en_o)
      mem_c[wr_addr_o] <= wr_data_o;
  end

  always @(negedge clk) begin
    if (rst_n_i) begin
      if (done_o)
        done_cnt++;
      if (wr_en_o) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: write addr %0d data %h, none expected",
                   wr_addr_o, wr_data_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (wr_addr_o !== e.addr || wr_data_o !== e.data) begin
            errors++;
            $display("FAIL sb_data: got addr %0d data %h, want addr %0d data %h",
                     wr_addr_o, wr_data_o, e.addr, e.data);
          end
        end
      end
    end
  end

  function automatic logic [22:0] model(input logic op, input logic [22:0] q,
                                        input logic [22:0] a, input logic [22:0] b);
    longint s;
    if (op)
      s = (longint'(a) + longint'(q) - longint'(b)) % longint'(q);
    else
      s = (longint'(a) + longint'(b)) % longint'(q);
    return s[22:0];
  endfunction

  task automatic start_pass(input logic op, input logic [22:0] q, input int nexp);
    for (int k = 0; k < nexp; k++) begin
      exp_t e;
      e.addr = AW'(k);
      e.data = model(op, q, mem_a[k], mem_b[k]);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start_i = 1'b1;
    op_i    = op;
    q_i     = q;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int from, output int at);
    at = -1;
    for (int c = from; c < from + 400; c++) begin
      @(negedge clk);
      if (done_o) begin
        at = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    start_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({rd_en_o, wr_en_o, busy_o, done_o, range_err_o} !== 5'b0 ||
        rd_addr_o !== '0 || wr_addr_o !== '0 || wr_data_o !== '0) begin
      errors++;
      $display("FAIL reset: rd_en %b wr_en %b busy %b done %b err %b, want all 0",
               rd_en_o, wr_en_o, busy_o, done_o, range_err_o);
    end
    start_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || rd_en_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy %b rd_en %b, want 0 0", busy_o, rd_en_o);
    end
  endtask

  task automatic test_add();
    int at;
    for (int k = 0; k < N; k++) begin
      mem_a[k] = 23'(k);
      mem_b[k] = Q - 23'd1;
    end
    start_pass(1'b0, Q, N);
    wait_done(1, at);
    checks++;
    if (at != N + 3) begin
      errors++;
      $display("FAIL add_done: done at cycle %0d, want %0d", at, N + 3);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mem_c[0] !== 23'h7FE000 || mem_c[5] !== 23'd4 || mem_c[255] !== 23'd254) begin
      errors++;
      $display("FAIL add_data: c0 %h c5 %h c255 %h, want 7fe000 4 fe",
               mem_c[0], mem_c[5], mem_c[255]);
    end
    checks++;
    if (range_err_o !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL add_end: err %b pending %0d, want 0 0", range_err_o, exp_q.size());
    end
  endtask

  task automatic test_sub();
    int at;
    for (int k = 0; k < N; k++) begin
      mem_a[k] = 23'd5;
      mem_b[k] = 23'd7;
    end
    start_pass(1'b1, Q, N);
    wait_done(1, at);
    @(posedge clk);
    #1;
    checks++;
    if (at != N + 3 || mem_c[100] !== 23'h7FDFFF) begin
      errors++;
      $display("FAIL sub: done cycle %0d c100 %h, want %0d 7fdfff", at, mem_c[100], N + 3);
    end
    for (int k = 0; k < N; k++)
      mem_b[k] = 23'd0;
    start_pass(1'b1, Q, N);
    wait_done(1, at);
    @(posedge clk);
    #1;
    checks++;
    if (at != N + 3 || mem_c[200] !== 23'd5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL sub_b0: done cycle %0d c200 %h, want %0d 5", at, mem_c[200], N + 3);
    end
  endtask

  task automatic test_timing();
    logic e_rd, e_wr, e_busy, e_done;
    for (int k = 0; k < N; k++) begin
      mem_a[k] = 23'(3 * k);
      mem_b[k] = 23'(k + 11);
    end
    start_pass(1'b0, Q, N);
    for (int c = 1; c <= N + 4; c++) begin
      @(negedge clk);
      e_rd   = (c <= N);
      e_wr   = (c >= 3 && c <= N + 2);
      e_busy = (c <= N + 2);
      e_done = (c == N + 3);
      checks++;
      if (rd_en_o !== e_rd || busy_o !== e_busy || done_o !== e_done ||
          wr_en_o !== e_wr ||
          (e_rd && rd_addr_o !== AW'(c - 1)) ||
          (e_wr && wr_addr_o !== AW'(c - 3))) begin
        errors++;
        $display("FAIL timing c%0d: rd %b/%0d wr %b/%0d busy %b done %b, want rd %b wr %b busy %b done %b",
                 c, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, busy_o, done_o,
                 e_rd, e_wr, e_busy, e_done);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timing_count: %0d writes missing, want 0", exp_q.size());
    end
  endtask

  task automatic test_abort();
    int w0, d0, at;
    w0 = wr_cnt;
    d0 = done_cnt;
    start_pass(1'b0, Q, 7);
    for (int c = 1; c <= 9; c++)
      @(negedge clk);
    @(posedge clk);
    #1;
    abort_i = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_c10: wr_en %b, want 0", wr_en_o);
    end
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    for (int c = 11; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if (wr_en_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || rd_en_o !== 1'b0) begin
        errors++;
        $display("FAIL abort c%0d: wr %b busy %b done %b rd %b, want 0",
                 c, wr_en_o, busy_o, done_o, rd_en_o);
      end
    end
    checks++;
    if (wr_cnt - w0 != 7 || done_cnt != d0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_count: writes %0d dones %0d, want 7 0",
               wr_cnt - w0, done_cnt - d0);
    end
    start_pass(1'b0, Q, N);
    wait_done(1, at);
    @(posedge clk);
    #1;
    checks++;
    if (at != N + 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_restart: done cycle %0d pending %0d, want %0d 0",
               at, exp_q.size(), N + 3);
    end
  endtask

  task automatic test_start_ignored();
    int w0, d0, at;
    w0 = wr_cnt;
    d0 = done_cnt;
    start_pass(1'b0, Q, N);
    for (int c = 1; c <= 49; c++)
      @(negedge clk);
    @(posedge clk);
    #1;
    start_i = 1'b1;
    op_i    = 1'b1;
    q_i     = 23'd123;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(51, at);
    repeat (6) @(negedge clk);
    checks++;
    if (at != N + 3 || wr_cnt - w0 != N || done_cnt - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL start_ignored: done cycle %0d writes %0d dones %0d, want %0d %0d 1",
               at, wr_cnt - w0, done_cnt - d0, N + 3, N);
    end
  endtask

  task automatic test_range_err();
    int at;
    logic e;
    for (int k = 0; k < N; k++) begin
      mem_a[k] = 23'(k);
      mem_b[k] = 23'd1;
    end
    mem_b[3] = Q;
    start_pass(1'b0, Q, N);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      e = (c >= 5);
      checks++;
      if (range_err_o !== e) begin
        errors++;
        $display("FAIL range c%0d: err %b, want %b", c, range_err_o, e);
      end
    end
    wait_done(13, at);
    repeat (3) @(negedge clk);
    checks++;
    if (at != N + 3 || range_err_o !== 1'b1 || mem_c[3] !== 23'd3) begin
      errors++;
      $display("FAIL range_hold: done %0d err %b c3 %h, want %0d 1 3",
               at, range_err_o, mem_c[3], N + 3);
    end
    mem_b[3] = 23'd1;
    start_pass(1'b0, Q, N);
    @(negedge clk);
    checks++;
    if (range_err_o !== 1'b0) begin
      errors++;
      $display("FAIL range_clear: err %b, want 0", range_err_o);
    end
    wait_done(2, at);
    @(posedge clk);
    #1;
    checks++;
    if (at != N + 3 || range_err_o !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL range_clean: done %0d err %b, want %0d 0", at, range_err_o, N + 3);
    end
  endtask

  task automatic test_reset_mid();
    int at;
    mem_b[9] = Q + 23'd4;
    start_pass(1'b0, Q, N);
    for (int c = 1; c <= 20; c++)
      @(negedge clk);
    @(posedge clk);
    #1;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({rd_en_o, wr_en_o, busy_o, done_o, range_err_o} !== 5'b0 ||
        rd_addr_o !== '0 || wr_data_o !== '0) begin
      errors++;
      $display("FAIL reset_mid: rd %b wr %b busy %b done %b err %b, want all 0",
               rd_en_o, wr_en_o, busy_o, done_o, range_err_o);
    end
    exp_q.delete();
    mem_b[9] = 23'd1;
    @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    start_pass(1'b0, Q, N);
    wait_done(1, at);
    @(posedge clk);
    #1;
    checks++;
    if (at != N + 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_restart: done cycle %0d pending %0d, want %0d 0",
               at, exp_q.size(), N + 3);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_timing();
    test_abort();
    test_start_ignored();
    test_range_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
